// File: rtl/regfile_dump.sv
// regfile_dump: walks an inclusive RegFile address range on one read port and streams
// (address, data) beats over valid/ready. Optional XOR checksum beat: REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump #(
    parameter int W = 8,
    parameter int A = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A-1:0] StartAddr,
    input  logic [A-1:0] EndAddr,
    output logic [A-1:0] RdAddr,
    input  logic [W-1:0] RdData,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [W-1:0] OutData,
    output logic [A-1:0] OutAddr,
    output logic         OutLast,
    output logic         Busy,
    output logic         Done
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam logic [2:0] ST_CSUM = 3'd4;

    function automatic logic [W-1:0] csum_fold(input logic [W-1:0] acc, input logic [W-1:0] beat);
        csum_fold = acc ^ beat;
    endfunction

    logic [W-1:0] csum_r;
    logic [W-1:0] csum_s;
`endif

    logic [2:0]   state_r;
    logic [2:0]   state_s;
    logic [A-1:0] end_addr_r;
    logic [A-1:0] end_addr_s;
    logic [A-1:0] rd_addr_s;
    logic [W-1:0] out_data_s;
    logic [A-1:0] out_addr_s;
    logic         out_valid_s;
    logic         out_last_s;
    logic         handshake_s;

    assign handshake_s = OutValid & OutReady;

    // Next-state and next-output computation for the dump walker
    always_comb begin
        state_s     = state_r;
        end_addr_s  = end_addr_r;
        rd_addr_s   = RdAddr;
        out_data_s  = OutData;
        out_addr_s  = OutAddr;
        out_valid_s = OutValid;
        out_last_s  = OutLast;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        csum_s      = csum_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    rd_addr_s  = StartAddr;
                    end_addr_s = EndAddr;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    csum_s     = {W{1'b0}};
`endif
                    state_s    = ST_LOAD;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_LOAD: begin
                out_data_s  = RdData;
                out_addr_s  = RdAddr;
                out_valid_s = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                out_last_s  = 1'b0;
                csum_s      = csum_fold(csum_r, RdData);
`else
                out_last_s  = (RdAddr == end_addr_r);
`endif
                state_s     = ST_SEND;
            end
            ST_SEND: begin
                if (handshake_s) begin
                    if (OutAddr == end_addr_r) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        // Checksum beat follows back-to-back; valid stays high
                        out_data_s  = csum_r;
                        out_addr_s  = {A{1'b0}};
                        out_last_s  = 1'b1;
                        out_valid_s = 1'b1;
                        state_s     = ST_CSUM;
`else
                        out_valid_s = 1'b0;
                        out_last_s  = 1'b0;
                        state_s     = ST_DONE;
`endif
                    end else begin
                        rd_addr_s   = RdAddr + A'(1'b1);
                        out_valid_s = 1'b0;
                        state_s     = ST_LOAD;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (handshake_s) begin
                    out_valid_s = 1'b0;
                    out_last_s  = 1'b0;
                    state_s     = ST_DONE;
                end else begin
                    state_s     = ST_CSUM;
                end
            end
`endif
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                out_valid_s = 1'b0;
                out_last_s  = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= ST_IDLE;
            end_addr_r <= {A{1'b0}};
            RdAddr     <= {A{1'b0}};
            OutData    <= {W{1'b0}};
            OutAddr    <= {A{1'b0}};
            OutValid   <= 1'b0;
            OutLast    <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_r     <= {W{1'b0}};
`endif
        end else begin
            state_r    <= state_s;
            end_addr_r <= end_addr_s;
            RdAddr     <= rd_addr_s;
            OutData    <= out_data_s;
            OutAddr    <= out_addr_s;
            OutValid   <= out_valid_s;
            OutLast    <= out_last_s;
            Busy       <= (state_s != ST_IDLE);
            Done       <= (state_s == ST_DONE);
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_r     <= csum_s;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed testbench for regfile_dump with a behavioural register-file read port.
// Expected beats are derived from the bench's own register array.
module tb_regfile_dump;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic [3:0] StartAddr;
    logic [3:0] EndAddr;
    logic [3:0] RdAddr;
    logic [7:0] RdData;
    logic       OutValid;
    logic       OutReady;
    logic [7:0] OutData;
    logic [3:0] OutAddr;
    logic       OutLast;
    logic       Busy;
    logic       Done;

    logic [7:0] regs [16];
    int n_cmp;
    int n_err;
    int q_addr[$];
    int q_data[$];
    int q_last[$];

    assign RdData = regs[RdAddr];

    regfile_dump #(.W(8), .A(4)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .EndAddr(EndAddr),
        .RdAddr(RdAddr), .RdData(RdData), .OutValid(OutValid), .OutReady(OutReady),
        .OutData(OutData), .OutAddr(OutAddr), .OutLast(OutLast), .Busy(Busy), .Done(Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one dump, optionally stalling at one address and pulsing Start during the stall
    task automatic do_dump(input logic [3:0] sa, input logic [3:0] ea, input int stall_addr, input int stall_n);
        int stall_left;
        bit stalled_once;
        bit got_done;
        bit expect_done;
        logic [3:0] h_addr;
        logic [7:0] h_data;
        q_addr.delete(); q_data.delete(); q_last.delete();
        stall_left = stall_n; stalled_once = 1'b0; got_done = 1'b0; expect_done = 1'b0;
        h_addr = 4'd0; h_data = 8'd0;
        @(negedge Clk);
        Start = 1'b1; StartAddr = sa; EndAddr = ea; OutReady = 1'b1;
        @(negedge Clk);
        Start = 1'b0; StartAddr = sa + 4'd3; EndAddr = ea + 4'd5;
        check("lat_busy", {31'd0, Busy}, 32'd1);
        check("lat_valid_n1", {31'd0, OutValid}, 32'd0);
        @(negedge Clk);
        check("lat_valid_n2", {31'd0, OutValid}, 32'd1);
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            if (cyc > 0) @(negedge Clk);
            Start = 1'b0;
            if (expect_done) begin
                check("done_after_last", {31'd0, Done}, 32'd1);
                expect_done = 1'b0;
                got_done = Done;
            end else begin
                check("no_early_done", {31'd0, Done}, 32'd0);
            end
            if (!got_done) begin
                if (OutValid && int'(OutAddr) == stall_addr && stall_left > 0) begin
                    if (!stalled_once) begin
                        h_addr = OutAddr; h_data = OutData; stalled_once = 1'b1;
                        Start = 1'b1; StartAddr = 4'd9; EndAddr = 4'd9;
                    end else begin
                        check("hold_addr", {28'd0, OutAddr}, {28'd0, h_addr});
                        check("hold_data", {24'd0, OutData}, {24'd0, h_data});
                        check("hold_valid", {31'd0, OutValid}, 32'd1);
                    end
                    OutReady = 1'b0;
                    stall_left--;
                end else begin
                    OutReady = 1'b1;
                    if (OutValid) begin
                        q_addr.push_back(int'(OutAddr));
                        q_data.push_back(int'(OutData));
                        q_last.push_back(int'(OutLast));
                        expect_done = OutLast;
                    end
                end
            end
        end
        check("done_seen", {31'd0, got_done}, 32'd1);
        OutReady = 1'b1;
        @(negedge Clk);
        check("done_one_cycle", {31'd0, Done}, 32'd0);
        check("idle_after_done", {31'd0, Busy}, 32'd0);
    endtask

    // Compare collected beats against the bench's register model
    task automatic check_dump(input logic [3:0] sa, input logic [3:0] ea);
        logic [3:0] d;
        logic [3:0] a;
        logic [7:0] x;
        int n;
        int n_exp;
        d = ea - sa;
        n = int'(d) + 1;
        a = sa;
        x = 8'd0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        n_exp = n + 1;
`else
        n_exp = n;
`endif
        check("beat_count", q_addr.size(), n_exp);
        for (int k = 0; k < n; k++) begin
            if (k < q_addr.size()) begin
                check("beat_addr", q_addr[k], {28'd0, a});
                check("beat_data", q_data[k], {24'd0, regs[a]});
`ifdef REGFILE_DUMP_CHECKSUM_EN
                check("beat_last", q_last[k], 32'd0);
`else
                check("beat_last", q_last[k], (k == n - 1) ? 32'd1 : 32'd0);
`endif
            end
            x = x ^ regs[a];
            a = a + 4'd1;
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        if (n < q_addr.size()) begin
            check("csum_addr", q_addr[n], 32'd0);
            check("csum_data", q_data[n], {24'd0, x});
            check("csum_last", q_last[n], 32'd1);
        end
`endif
    endtask

    initial begin
        bit found;
        n_cmp = 0; n_err = 0;
        Reset = 1'b1; Start = 1'b0; StartAddr = 4'd0; EndAddr = 4'd0; OutReady = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 8'(3 * i);
        @(negedge Clk);
        @(negedge Clk);
        check("rst_valid", {31'd0, OutValid}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_last", {31'd0, OutLast}, 32'd0);
        check("rst_rdaddr", {28'd0, RdAddr}, 32'd0);
        check("rst_outaddr", {28'd0, OutAddr}, 32'd0);
        check("rst_outdata", {24'd0, OutData}, 32'd0);
        Reset = 1'b0;

        // Full range, sink always ready
        do_dump(4'd0, 4'd15, -1, 0);
        check_dump(4'd0, 4'd15);

        // Stall on address 4 for 5 cycles with a Start pulse mid-dump
        do_dump(4'd0, 4'd15, 4, 5);
        check_dump(4'd0, 4'd15);

        // Wrapping range
        do_dump(4'd14, 4'd1, -1, 0);
        check_dump(4'd14, 4'd1);

        // Reset during the third beat aborts the dump
        @(negedge Clk);
        Start = 1'b1; StartAddr = 4'd0; EndAddr = 4'd15; OutReady = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge Clk);
            if (OutValid && OutAddr == 4'd2) found = 1'b1;
        end
        check("rst_reach_beat3", {31'd0, found}, 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("abort_valid", {31'd0, OutValid}, 32'd0);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_done", {31'd0, Done}, 32'd0);
        check("abort_last", {31'd0, OutLast}, 32'd0);
        check("abort_rdaddr", {28'd0, RdAddr}, 32'd0);
        check("abort_outaddr", {28'd0, OutAddr}, 32'd0);
        check("abort_outdata", {24'd0, OutData}, 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            check("abort_no_done", {31'd0, Done}, 32'd0);
            check("abort_no_beat", {31'd0, OutValid}, 32'd0);
        end

        // Single-beat range after the abort
        regs[7] = 8'hA5;
        do_dump(4'd7, 4'd7, -1, 0);
        check_dump(4'd7, 4'd7);
        if (q_data.size() > 0) check("single_data", q_data[0], 32'h0000_00A5);

        // Small range used for the checksum beat
        regs[0] = 8'h01; regs[1] = 8'h02; regs[2] = 8'h04; regs[3] = 8'h08;
        do_dump(4'd0, 4'd3, -1, 0);
        check_dump(4'd0, 4'd3);
`ifdef REGFILE_DUMP_CHECKSUM_EN
        if (q_data.size() == 5) check("csum_value", q_data[4], 32'h0000_000F);
`else
        if (q_last.size() == 4) check("last_on_addr3", q_last[3], 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
